// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial add/subtract engine.
package serial_addsub_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_addsub_ctrl_full_adder_bit.sv
// One-bit full adder cell, purely combinational (zero latency, no flow control).
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub, LSB first through one full_adder_bit; done WIDTH+1 cycles after accept, start ignored unless ready.
// Optional signed-overflow output is built only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;

  // Operands shift right so the cell always sees bit 0; no variable indexing.
  assign fa_b = b_sh[0] ^ op_q;

  full_adder_bit u_fa (
    .a    (a_sh[0]),
    .b    (fa_b),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    acc_next            = acc >> 1;
    acc_next[WIDTH-1]   = fa_sum;
  end

  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_RUN);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op_t'(op);
            carry <= op;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_next;
          carry <= fa_cout;
          cnt   <= cnt + ONE;
          if (cnt == LAST) begin
            // Visible outputs change only here, so result holds through the run.
            cnt       <= '0;
            result    <= acc_next;
            carry_out <= fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf       <= carry ^ fa_cout;
`endif
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (WIDTH=4) with a cycle-level reference model and literal checks.
module tb_serial_addsub_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: age = edges since acceptance (-1 when idle).
  bit           armed = 1'b0;
  int           age   = -1;
  logic [W-1:0] m_res = '0;
  logic         m_c   = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_res;
  logic         p_c;
  logic         p_ovf;

  always @(posedge clk) begin
    if (rst) begin
      age   = -1;
      m_res = '0;
      m_c   = 1'b0;
      m_ovf = 1'b0;
      armed = 1'b1;
    end else if (age == -1) begin
      if (start) begin
        int ua, ub, sa, sb, raw, sr;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua >= 8) ? ua - 16 : ua;
        sb  = (ub >= 8) ? ub - 16 : ub;
        raw = op ? ua - ub : ua + ub;
        sr  = op ? sa - sb : sa + sb;
        p_res = W'(((raw % 16) + 16) % 16);
        p_c   = op ? (ua >= ub) : (raw >= 16);
        p_ovf = (sr > 7) || (sr < -8);
        age   = 0;
      end
    end else if (age == W) begin
      age = -1;
    end else begin
      age++;
      if (age == W) begin
        m_res = p_res;
        m_c   = p_c;
        m_ovf = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_ready", 32'(ready), 32'(age == -1));
      chk("model_busy", 32'(busy), 32'(age >= 0 && age < W));
      chk("model_done", 32'(done), 32'(age == W));
      chk("model_result", 32'(result), 32'(m_res));
      chk("model_carry", 32'(carry_out), 32'(m_c));
`ifdef SERIAL_ADDSUB_OVF_EN
      chk("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic run_op(input string nm, input logic o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] er,
                        input logic ec, input logic eovf);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(W + 1));
    chk({nm, "_result"}, 32'(result), 32'(er));
    chk({nm, "_carry"}, 32'(carry_out), 32'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) chk({nm, "_ovf_arg"}, 32'(eovf), 32'(1'b0));
`endif
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_result", 32'(result), 32'(0));
    chk("reset_carry", 32'(carry_out), 32'(0));
    rst = 1'b0;

    run_op("add3p5", 1'b0, 4'd3, 4'd5, 4'd8, 1'b0, 1'b1);
    run_op("add15p1", 1'b0, 4'd15, 4'd1, 4'd0, 1'b1, 1'b0);
    run_op("add2p2", 1'b0, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0);
    run_op("sub5m3", 1'b1, 4'd5, 4'd3, 4'd2, 1'b1, 1'b0);
    run_op("sub3m5", 1'b1, 4'd3, 4'd5, 4'he, 1'b0, 1'b0);
    run_op("sub8m1", 1'b1, 4'd8, 4'd1, 4'd7, 1'b1, 1'b1);

    // Second start two cycles into a run must be dropped.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 4'd3; b = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        pulses++;
        chk("ignored_start_result", 32'(result), 32'(8));
      end
      @(negedge clk);
    end
    chk("ignored_start_pulses", 32'(pulses), 32'(1));

    run_op("sub5m3_again", 1'b1, 4'd5, 4'd3, 4'd2, 1'b1, 1'b0);

    // Reset two cycles into a run abandons it.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 4'd7; b = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_ready", 32'(ready), 32'(1));
    chk("midrun_rst_result", 32'(result), 32'(0));
    chk("midrun_rst_carry", 32'(carry_out), 32'(0));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("midrun_rst_no_done", 32'(pulses), 32'(0));

    run_op("add6p6", 1'b0, 4'd6, 4'd6, 4'd12, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
